// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with overlap control and a saturating match counter.
// Match pulse is registered one cycle after the final pattern bit; no backpressure (accepts on in_valid).
module seq_detect_param #(
    parameter int                 PAT_LEN     = 4,
    parameter logic [PAT_LEN-1:0] DEFAULT_PAT = PAT_LEN'(4'b1101),
    parameter int                 CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_pattern,
    input  logic [PAT_LEN-1:0] pattern_in,
    input  logic               in_valid,
    input  logic               i,
    input  logic               overlap,
    input  logic               clear_count,
    output logic               o,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat
);
    localparam int FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FULL    = FILL_W'(PAT_LEN);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {FILL, ARMED} state_t;

    state_t             state_q;
    logic [PAT_LEN-1:0] pattern_q;
    logic [PAT_LEN-1:0] history_q;
    logic [FILL_W-1:0]  fill_q;
    logic               o_q;
    logic [CNT_W-1:0]   count_q;
    logic               sat_q;

    logic               accept;
    logic [PAT_LEN-1:0] history_d;
    logic [FILL_W-1:0]  fill_d;
    logic               match;
    logic [CNT_W-1:0]   count_d;

    always_comb begin
        accept    = in_valid && !load_pattern;
        history_d = {history_q[PAT_LEN-2:0], i};
        // Once armed the fill count is pinned at PAT_LEN.
        fill_d    = (state_q == ARMED) ? FULL : fill_q + FILL_W'(1);
        match     = accept && (fill_d == FULL) && (history_d == pattern_q);

        if (clear_count)
            count_d = match ? CNT_W'(1) : '0;
        else if (match && (count_q != CNT_MAX))
            count_d = count_q + CNT_W'(1);
        else
            count_d = count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_q <= DEFAULT_PAT;
            history_q <= '0;
            fill_q    <= '0;
            state_q   <= FILL;
            o_q       <= 1'b0;
            count_q   <= '0;
            sat_q     <= 1'b0;
        end else begin
            o_q     <= match;
            count_q <= count_d;
            sat_q   <= (count_d == CNT_MAX);
            if (load_pattern) begin
                pattern_q <= pattern_in;
                history_q <= '0;
                fill_q    <= '0;
                state_q   <= FILL;
            end else if (in_valid) begin
                history_q <= history_d;
                // Non-overlapping mode restarts collection after every hit.
                if (match && !overlap) begin
                    fill_q  <= '0;
                    state_q <= FILL;
                end else begin
                    fill_q  <= fill_d;
                    state_q <= (fill_d == FULL) ? ARMED : FILL;
                end
            end
        end
    end

    assign o           = o_q;
    assign match_count = count_q;
    assign count_sat   = sat_q;
endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised serial pattern detector; successor to the fixed 4-bit Moore sequence detector.
- Watches a qualified 1-bit serial stream and raises a one-cycle registered match pulse whenever the last PAT_LEN accepted bits equal a run-time programmable pattern.
- Adds overlapping / non-overlapping detection modes and a saturating match counter.
- Sits behind the serial receive logic; `o` and `match_count` feed control/status.

Parameters:
- PAT_LEN, 4, pattern length in bits (legal range 2..32).
- DEFAULT_PAT, 4'b1101, pattern loaded at reset (PAT_LEN bits wide).
- CNT_W, 8, match counter width (legal range 1..16).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- load_pattern  input  1  load pattern_in into pattern register.
- pattern_in  input  PAT_LEN  new pattern; bit PAT_LEN-1 is matched against the oldest bit.
- in_valid  input  1  qualifies i; bit accepted only when high.
- i  input  1  serial data bit.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- clear_count  input  1  clear match counter.
- o  output  1  registered match pulse.
- match_count  output  CNT_W  saturating count of matches.
- count_sat  output  1  high while match_count is at its maximum (all ones).

Behaviour:
- Reset, sampled on rising clk while rst=1, overrides all other inputs:
  - pattern = DEFAULT_PAT
  - history = 0, fill = 0, state = FILL
  - o = 0, match_count = 0, count_sat = 0
- Internal state:
  - history: PAT_LEN-bit shift register.
  - fill: counter 0..PAT_LEN.
  - Two-state FSM: FILL (fill < PAT_LEN) and ARMED (fill == PAT_LEN).
- Bit accept (in_valid=1, load_pattern=0):
  - history_next = {history[PAT_LEN-2:0], i}.
  - fill_next = min(fill+1, PAT_LEN).
- Match condition: bit accepted AND fill_next == PAT_LEN AND history_next == pattern.
- o latency:
  - o is registered: o <= match at the same edge that accepts the final pattern bit.
  - o is high for exactly the following cycle per match.
  - Back-to-back matches hold o high on consecutive cycles.
- Overlap modes:
  - overlap=1: after a match, fill stays PAT_LEN (ARMED); suffix bits are reused.
  - overlap=0: after a match, fill <= 0 (FILL); the next match needs PAT_LEN new bits.
  - overlap is sampled every accepted bit; changing it mid-stream affects only matches from that edge on.
- in_valid=0: history, fill and state hold; o <= 0.
- load_pattern=1:
  - pattern <= pattern_in; history <= 0; fill <= 0; o <= 0.
  - Any bit presented in the same cycle is discarded.
  - match_count is unchanged.
- match_count update:
  - On match, +1, saturating at 2^CNT_W-1; no wrap.
  - count_sat = (match_count == all ones), registered alongside the count.
- clear_count update:
  - clear_count=1 with no match: match_count <= 0.
  - clear_count=1 with a match in the same cycle: match_count <= 1; o still pulses.
- Priority: rst > load_pattern > bit accept; clear_count combines with a match as above.
- Reset mid-stream discards any partial pattern; the first match after reset needs PAT_LEN fresh accepted bits.
- No combinational path from any input to any output.

Test Plan:
- Default pattern 1101, overlap=1, in_valid=1, stream 1,1,0,1,1,0,1 -> o pulses on the cycles after the 4th and 7th bits; match_count=2.
- Same stream, overlap=0 -> single o pulse after the 4th bit; match_count=1; fill returns to 0 after the match.
- load_pattern with pattern_in=4'b0110 while in_valid=1, i=1 -> that bit is discarded; stream 0,1,1,0 -> one pulse; stream 1,1,0,1 -> no pulse.
- Stream 1,1,(in_valid=0 for 3 cycles),0,1 -> match after the final bit; o=0 during the gap cycles.
- CNT_W=2, overlap=1, stream 1101101101101 -> count 1,2,3,3 with count_sat=1 from the 3rd match; then clear_count coincident with a 5th match -> match_count=1, count_sat=0.
- rst asserted after stream 1,1,0 and released, then stream 1 -> no pulse; full 1,1,0,1 -> pulse; all outputs read 0 during rst.
